// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction-memory write-side loader. Packs an 8-bit
//                valid/ready byte stream MSB-first into 32-bit words, writes
//                them to consecutive word addresses from 0 and holds the CPU
//                until the whole program has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_WRITE   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    // Memory depth in words; the largest load length that does not wrap.
    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_word_cnt;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_shift;
    logic            r_zero_pend;
    logic            r_cpu_hold;
    logic            r_done;

    logic            w_start_ok;
    logic            w_len_zero;
    logic [ADDR_W:0] w_len_clamped;
    logic            w_accept;
    logic [ADDR_W:0] w_word_cnt_inc;
    logic            w_last_word;

    // A zero-length start spends one extra cycle in IDLE (r_zero_pend) so
    // that DONE is entered on the second edge after the start pulse; a new
    // start is not taken while that pending transition is outstanding.
    assign w_start_ok     = start & (((r_state == c_IDLE) & ~r_zero_pend) |
                                     (r_state == c_DONE));
    assign w_len_zero     = (len_words == '0);
    assign w_len_clamped  = (len_words > c_DEPTH) ? c_DEPTH : len_words;
    assign w_accept       = (r_state == c_COLLECT) & in_valid;
    assign w_word_cnt_inc = r_word_cnt + c_ONE;
    assign w_last_word    = (w_word_cnt_inc == r_len);

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_zero_pend) begin
                    w_state_nxt = c_DONE;
                end else if (w_start_ok) begin
                    w_state_nxt = w_len_zero ? c_IDLE : c_COLLECT;
                end
            end
            c_COLLECT: begin
                if (w_accept && (r_byte_cnt == 2'd3)) begin
                    w_state_nxt = c_WRITE;
                end
            end
            c_WRITE: begin
                w_state_nxt = w_last_word ? c_DONE : c_COLLECT;
            end
            c_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = w_len_zero ? c_IDLE : c_COLLECT;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered CPU hold / done: both change on the edge that enters or leaves DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_cpu_hold <= (w_state_nxt != c_DONE);
            r_done     <= (w_state_nxt == c_DONE);
        end
    end

    // Length latch, word/byte counters and the byte packing shift register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_zero_pend <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_len       <= w_len_clamped;
                r_word_cnt  <= '0;
                r_byte_cnt  <= '0;
                r_zero_pend <= w_len_zero;
            end else if ((r_state == c_IDLE) && r_zero_pend) begin
                r_zero_pend <= 1'b0;
            end

            if (w_accept) begin
                r_shift    <= {r_shift[23:0], in_data};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            if (r_state == c_WRITE) begin
                r_word_cnt <= w_word_cnt_inc;
                r_byte_cnt <= '0;
            end
        end
    end

    assign in_ready  = (r_state == c_COLLECT);
    assign busy      = (r_state == c_COLLECT) | (r_state == c_WRITE);
    assign mem_we    = (r_state == c_WRITE);
    assign mem_addr  = (r_state == c_WRITE) ? r_word_cnt[ADDR_W-1:0] : '0;
    assign mem_wdata = (r_state == c_WRITE) ? r_shift : '0;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Scoreboard bench for imem_loader. Main instance uses
//                ADDR_W=10; a second instance with ADDR_W=2 covers clamping.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    int          cyc;

    logic        start;
    logic [10:0] len_words;
    logic        in_ready, mem_we, cpu_hold, busy, done;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    logic        start2;
    logic [2:0]  len_words2;
    logic        in_ready2, mem_we2, cpu_hold2, busy2, done2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;

    wr_t q1[$];
    wr_t q2[$];
    int  n_vec;
    int  n_err;

    imem_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len_words (len_words),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done)
    );

    imem_loader #(.ADDR_W(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start2),
        .len_words (len_words2),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .mem_we    (mem_we2),
        .mem_addr  (mem_addr2),
        .mem_wdata (mem_wdata2),
        .cpu_hold  (cpu_hold2),
        .busy      (busy2),
        .done      (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until the selected instance accepts it.
    task automatic send_byte(input logic [7:0] b, input bit on2, output int acc_cyc);
        logic r;
        int   n;
        in_data  = b;
        in_valid = 1'b1;
        n        = 0;
        acc_cyc  = cyc;
        do begin
            r       = on2 ? in_ready2 : in_ready;
            acc_cyc = cyc;
            tick();
            n++;
        end while (!r && n < 50);
        if (!r) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: byte 0x%02h never accepted, expected accept within 50 cycles", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit on2, output int acc_cyc);
        int t;
        send_byte(w[31:24], on2, acc_cyc);
        send_byte(w[23:16], on2, t);
        send_byte(w[15:8],  on2, t);
        send_byte(w[7:0],   on2, t);
    endtask

    task automatic start_load(input logic [10:0] len, input bit on2);
        if (on2) begin
            len_words2 = len[2:0];
            start2     = 1'b1;
        end else begin
            len_words  = len;
            start      = 1'b1;
        end
        tick();
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input bit on2, input string name, output int done_cyc);
        int n;
        n = 0;
        while (!(on2 ? done2 : done) && n < 60) begin
            tick();
            n++;
        end
        done_cyc = cyc;
        check(name, {31'd0, (on2 ? done2 : done)}, 32'd1);
    endtask

    // Monitor for the ADDR_W=10 instance.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut1_unexpected_write: addr 0x%0h data 0x%08h, expected no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = q1.pop_front();
                check("dut1_addr", {22'd0, mem_addr}, e.addr);
                check("dut1_data", mem_wdata, e.data);
            end
        end
    end

    // Monitor for the ADDR_W=2 instance.
    always @(negedge clk) begin
        if (mem_we2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut2_unexpected_write: addr 0x%0h data 0x%08h, expected no write", mem_addr2, mem_wdata2);
            end else begin
                wr_t e;
                e = q2.pop_front();
                check("dut2_addr", {30'd0, mem_addr2}, e.addr);
                check("dut2_data", mem_wdata2, e.data);
            end
        end
    end

    // Directed stimulus.
    initial begin
        int t_acc, t_done, t;
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        start2     = 1'b0;
        len_words  = '0;
        len_words2 = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        tick();
        tick();
        // Reset values: {in_ready, mem_we, cpu_hold, busy, done}.
        check("reset_flags", {27'd0, in_ready, mem_we, cpu_hold, busy, done}, 32'h4);
        check("reset_addr", {22'd0, mem_addr}, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: three-word program, valid held high.
        q1.push_back('{32'd0, 32'h20110005});
        q1.push_back('{32'd1, 32'h20120013});
        q1.push_back('{32'd2, 32'h02328020});
        start_load(11'd3, 1'b0);
        check("t1_busy_hold", {30'd0, busy, cpu_hold}, 32'h3);
        send_word(32'h20110005, 1'b0, t_acc);
        send_word(32'h20120013, 1'b0, t);
        send_word(32'h02328020, 1'b0, t);
        wait_done(1'b0, "t1_done", t_done);
        in_valid = 1'b0;
        check("t1_done_latency", t_done - t_acc, 32'd15);
        check("t1_done_flags", {29'd0, cpu_hold, busy, in_ready}, 32'h0);

        // 2: 3-cycle valid gap between bytes 2 and 3.
        q1.push_back('{32'd0, 32'hDEADBEEF});
        start_load(11'd1, 1'b0);
        send_byte(8'hDE, 1'b0, t_acc);
        send_byte(8'hAD, 1'b0, t);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_gap_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        send_byte(8'hBE, 1'b0, t);
        send_byte(8'hEF, 1'b0, t);
        wait_done(1'b0, "t2_done", t_done);
        in_valid = 1'b0;
        check("t2_done_latency", t_done - t_acc, 32'd8);

        // 3: zero-length load.
        start_load(11'd0, 1'b0);
        check("t3_cycle1_done_hold", {30'd0, done, cpu_hold}, 32'h1);
        tick();
        check("t3_cycle2_done_hold", {30'd0, done, cpu_hold}, 32'h2);

        // 4: reset in the middle of a word.
        start_load(11'd1, 1'b0);
        send_byte(8'hAA, 1'b0, t);
        send_byte(8'hBB, 1'b0, t);
        in_data = 8'hCC;
        reset_n = 1'b0;
        tick();
        check("t4_reset_flags", {27'd0, in_ready, mem_we, cpu_hold, busy, done}, 32'h4);
        check("t4_reset_addr", {22'd0, mem_addr}, 32'd0);
        check("t4_reset_wdata", mem_wdata, 32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        tick();
        q1.push_back('{32'd0, 32'h11223344});
        start_load(11'd1, 1'b0);
        send_word(32'h11223344, 1'b0, t);
        in_valid = 1'b0;
        wait_done(1'b0, "t4_done", t_done);

        // 6: reload from DONE.
        q1.push_back('{32'd0, 32'h00000000});
        start_load(11'd1, 1'b0);
        check("t6_hold_after_start", {30'd0, cpu_hold, done}, 32'h2);
        send_word(32'h00000000, 1'b0, t);
        in_valid = 1'b0;
        wait_done(1'b0, "t6_done", t_done);
        check("t6_hold_released", {31'd0, cpu_hold}, 32'd0);

        // 5: ADDR_W=2 instance, len 7 clamped to 4, start pulse mid-word ignored.
        q2.push_back('{32'd0, 32'hA0A1A2A3});
        q2.push_back('{32'd1, 32'hB0B1B2B3});
        q2.push_back('{32'd2, 32'hC0C1C2C3});
        q2.push_back('{32'd3, 32'hD0D1D2D3});
        start_load(11'd7, 1'b1);
        send_word(32'hA0A1A2A3, 1'b1, t);
        send_byte(8'hB0, 1'b1, t);
        len_words2 = 3'd1;
        start2     = 1'b1;
        send_byte(8'hB1, 1'b1, t);
        start2     = 1'b0;
        send_byte(8'hB2, 1'b1, t);
        send_byte(8'hB3, 1'b1, t);
        send_word(32'hC0C1C2C3, 1'b1, t);
        send_word(32'hD0D1D2D3, 1'b1, t);
        wait_done(1'b1, "t5_done", t_done);
        in_valid = 1'b0;
        check("t5_done_ready", {31'd0, in_ready2}, 32'd0);
        repeat (5) tick();

        check("q1_drained", q1.size(), 32'd0);
        check("q2_drained", q2.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
